// File: rtl/vector_reorder.sv
// ============================================================================
// vector_reorder: buffers one vector of up to DEPTH elements and replays it
// in reverse or forward order. Macro VECTOR_REORDER_OVF_DROP_EN discards overflowed vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vector_reorder #(
   parameter int DATA_W = 3,
   parameter int DEPTH  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in,
   input  logic              mode,
   output logic              out_valid,
   output logic [DATA_W-1:0] out,
   output logic              ovf
);

   localparam int LEN_W = $clog2(DEPTH + 1);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

`ifdef VECTOR_REORDER_OVF_DROP_EN
   typedef enum logic [1:0] {IDLE, INPUT, OUTPUT, DROP} state_t;
`else
   typedef enum logic [1:0] {IDLE, INPUT, OUTPUT} state_t;
`endif

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                mode_q, mode_d;
   logic                ovf_seen_q, ovf_seen_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_q, out_d;
   logic                ovf_q, ovf_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                wr_en;
   logic [LEN_W-1:0]    wr_idx;
   logic [LEN_W-1:0]    rd_idx;

   // mode=1 replays from element 0 upward, mode=0 from element len-1 downward
   assign rd_idx = mode_q ? cnt_q : (len_q - LEN_ONE - cnt_q);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      ovf_seen_d  = ovf_seen_q;
      out_valid_d = 1'b0;
      out_d       = '0;
      ovf_d       = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = len_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               wr_en      = 1'b1;
               wr_idx     = '0;
               len_d      = LEN_ONE;
               cnt_d      = '0;
               mode_d     = mode;
               ovf_seen_d = 1'b0;
               state_d    = INPUT;
            end
         end

         INPUT: begin
            if (in_valid) begin
               if (len_q == LEN_MAX) begin
                  ovf_seen_d = 1'b1;
               end else begin
                  wr_en  = 1'b1;
                  len_d  = len_q + LEN_ONE;
               end
            end else begin
               cnt_d   = '0;
               state_d = OUTPUT;
`ifdef VECTOR_REORDER_OVF_DROP_EN
               if (ovf_seen_q) begin
                  state_d = DROP;
               end
`endif
            end
         end

         OUTPUT: begin
            out_valid_d = 1'b1;
            out_d       = mem_q[rd_idx];
            ovf_d       = ovf_seen_q && (cnt_q == '0);
            cnt_d       = cnt_q + LEN_ONE;
            // Leaving OUTPUT on the last element frees the final out_valid cycle for a new vector
            if (cnt_q == (len_q - LEN_ONE)) begin
               state_d = IDLE;
            end
         end

`ifdef VECTOR_REORDER_OVF_DROP_EN
         DROP: begin
            ovf_d   = ovf_seen_q;
            state_d = IDLE;
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         ovf_seen_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         ovf_seen_q  <= ovf_seen_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         ovf_q       <= ovf_d;
      end
   end

   // Storage is never read before being written for the current vector, so it needs no reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= in;
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_vector_reorder.sv
// ============================================================================
// tb_vector_reorder: directed self-checking bench for vector_reorder (DATA_W=3, DEPTH=6).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vector_reorder;

   localparam int DW = 3;
   localparam int DP = 6;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] din      = '0;
   logic          mode     = 1'b0;
   logic          out_valid;
   logic [DW-1:0] dout;
   logic          ovf;

   int n_checks = 0;
   int n_pass   = 0;

   int stim_v [8];
   int stim_m [8];
   int stim_n;
   int exp_v  [8];
   int exp_n;
   int exp_ovf;

   vector_reorder #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in        (din),
      .mode      (mode),
      .out_valid (out_valid),
      .out       (dout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int expv);
      n_checks++;
      if (got == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives stim_*, then watches 20 edges after the last beat's edge.
   task automatic run_vec(input string tag);
      int got [$];
      int first_e, last_e, ovf_cnt, ovf_e, zero_bad;
      first_e = -1; last_e = -1; ovf_cnt = 0; ovf_e = -1; zero_bad = 0;
      for (int i = 0; i < stim_n; i++) begin
         in_valid = 1'b1;
         din      = stim_v[i][DW-1:0];
         mode     = stim_m[i][0];
         tick();
      end
      in_valid = 1'b0;
      din      = '0;
      mode     = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (out_valid) begin
            if (first_e < 0) first_e = c;
            last_e = c;
            got.push_back(int'(dout));
         end else if (dout != '0) begin
            zero_bad++;
         end
         if (ovf) begin
            ovf_cnt++;
            ovf_e = c;
         end
      end
      check({tag, " count"}, got.size(), exp_n);
      for (int i = 0; i < exp_n; i++)
         check($sformatf("%s elem%0d", tag, i), (i < got.size()) ? got[i] : -1, exp_v[i]);
      if (exp_n > 0) begin
         check({tag, " first_edge"}, first_e, 2);
         check({tag, " contiguous"}, last_e - first_e + 1, exp_n);
      end
      check({tag, " ovf_pulses"}, ovf_cnt, exp_ovf);
      if (exp_ovf > 0) check({tag, " ovf_edge"}, ovf_e, 2);
      check({tag, " out_zero_idle"}, zero_bad, 0);
   endtask

   initial begin
      int extra;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst out_valid", int'(out_valid), 0);
      check("rst out", int'(dout), 0);
      check("rst ovf", int'(ovf), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Reverse order, full-depth vector
      stim_n = 6; stim_v = '{1, 2, 3, 4, 5, 6, 0, 0}; stim_m = '{0, 0, 0, 0, 0, 0, 0, 0};
      exp_n  = 6; exp_v  = '{6, 5, 4, 3, 2, 1, 0, 0}; exp_ovf = 0;
      run_vec("rev6");

      // Forward order, mode toggled after the first beat
      stim_n = 3; stim_v = '{7, 0, 5, 0, 0, 0, 0, 0}; stim_m = '{1, 0, 1, 0, 0, 0, 0, 0};
      exp_n  = 3; exp_v  = '{7, 0, 5, 0, 0, 0, 0, 0}; exp_ovf = 0;
      run_vec("fwd3");

      // Overflow: 8 beats
      stim_n = 8; stim_v = '{1, 2, 3, 4, 5, 6, 7, 0}; stim_m = '{0, 0, 0, 0, 0, 0, 0, 0};
`ifdef VECTOR_REORDER_OVF_DROP_EN
      exp_n  = 0; exp_v  = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
      exp_n  = 6; exp_v  = '{6, 5, 4, 3, 2, 1, 0, 0};
`endif
      exp_ovf = 1;
      run_vec("ovf8");

      // Single beat, then a new vector started in the final out_valid cycle
      in_valid = 1'b1; din = 3'd4; mode = 1'b1;
      tick();
      in_valid = 1'b0; din = '0;
      tick();
      check("single pre valid", int'(out_valid), 0);
      tick();
      check("single valid", int'(out_valid), 1);
      check("single out", int'(dout), 4);
      in_valid = 1'b1; din = 3'd2; mode = 1'b0;
      tick();
      check("single fall valid", int'(out_valid), 0);
      check("single fall out", int'(dout), 0);
      din = 3'd3; mode = 1'b1;
      tick();
      in_valid = 1'b0; din = '0; mode = 1'b0;
      tick();
      tick();
      check("chain e0 valid", int'(out_valid), 1);
      check("chain e0 out", int'(dout), 3);
      tick();
      check("chain e1 valid", int'(out_valid), 1);
      check("chain e1 out", int'(dout), 2);
      tick();
      check("chain end valid", int'(out_valid), 0);

      // in_valid during non-final output cycles is ignored
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1; din = DW'(i); mode = 1'b1;
         tick();
      end
      in_valid = 1'b0; din = '0;
      tick();
      in_valid = 1'b1; din = 3'd7; mode = 1'b0;
      tick();
      check("ign e0 out", int'(dout), 1);
      tick();
      check("ign e1 out", int'(dout), 2);
      in_valid = 1'b0; din = '0;
      tick();
      check("ign e2 out", int'(dout), 3);
      extra = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (out_valid || ovf) extra++;
      end
      check("ign no extra", extra, 0);

      // Reset during the third output cycle
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; din = DW'(i); mode = 1'b0;
         tick();
      end
      in_valid = 1'b0; din = '0;
      tick();
      tick();
      tick();
      tick();
      check("rstmid pre out", int'(dout), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid out_valid", int'(out_valid), 0);
      check("rstmid out", int'(dout), 0);
      check("rstmid ovf", int'(ovf), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (out_valid || ovf) extra++;
      end
      check("rstmid no output", extra, 0);
      stim_n = 2; stim_v = '{1, 2, 0, 0, 0, 0, 0, 0}; stim_m = '{0, 0, 0, 0, 0, 0, 0, 0};
      exp_n  = 2; exp_v  = '{2, 1, 0, 0, 0, 0, 0, 0}; exp_ovf = 0;
      run_vec("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
